// File: rtl/ysyx_23060025_icache_sa_pkg.sv
// Shared definitions for the set-associative instruction cache.
//   icache_state_e  : controller states (IDLE/LOOKUP/AR/REFILL/RESP)
//   AXI_BURST_INCR  : AXI arburst encoding for incrementing bursts
//   AXI_SIZE_4B     : AXI arsize encoding for 4-byte beats
//   clog2_min1()    : log2 that never returns 0, for index widths
package ysyx_23060025_icache_sa_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StAr,
        StRefill,
        StResp
    } icache_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_23060025_icache_sa_if.sv
// Bus bundle between the IFU, the instruction cache and the AXI read port.
//   in_*  : IFU fetch request/response and fence.i flush
//   out_* : AXI read-address and read-data channels
// Modports: slave = the cache, master = the IFU/memory side driving it.
interface ysyx_23060025_icache_sa_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] in_paddr;
    logic                  in_psel;
    logic                  in_flush;
    logic                  in_pready;
    logic [DATA_WIDTH-1:0] in_prdata;
    logic [ADDR_WIDTH-1:0] out_araddr;
    logic                  out_arvalid;
    logic                  out_arready;
    logic [7:0]            out_arlen;
    logic [2:0]            out_arsize;
    logic [1:0]            out_arburst;
    logic                  out_rvalid;
    logic [DATA_WIDTH-1:0] out_rdata;
    logic                  out_rlast;
    logic                  out_rready;

    modport slave (
        input  in_paddr, in_psel, in_flush, out_arready, out_rvalid, out_rdata, out_rlast,
        output in_pready, in_prdata, out_araddr, out_arvalid, out_arlen, out_arsize,
               out_arburst, out_rready
    );

    modport master (
        output in_paddr, in_psel, in_flush, out_arready, out_rvalid, out_rdata, out_rlast,
        input  in_pready, in_prdata, out_araddr, out_arvalid, out_arlen, out_arsize,
               out_arburst, out_rready
    );
endinterface

// File: rtl/ysyx_23060025_icache_sa_way.sv
// One way of the instruction cache: valid bits, tags and line data for every set.
//   set_idx/tag        : set being accessed and tag to compare against
//   hit/valid/rd_word  : lookup result, valid bit of the set, word rd_idx of the line
//   we/wr_idx/wr_data  : refill word write into the addressed set
//   install            : mark the set valid and store tag (last refill beat)
//   clear_all          : invalidate every set (fence.i)
// Only valid bits are reset; tag and data contents are don't-care until installed.
module ysyx_23060025_icache_sa_way
    import ysyx_23060025_icache_sa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_W      = 24,
    parameter int unsigned SET_ADDR_W = 4,
    parameter int unsigned WORDS      = 4,
    localparam int unsigned WORD_W    = clog2_min1(WORDS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SET_ADDR_W-1:0] set_idx,
    input  logic [TAG_W-1:0]      tag,
    input  logic [WORD_W-1:0]     rd_idx,
    output logic                  hit,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rd_word,
    input  logic                  we,
    input  logic [WORD_W-1:0]     wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  install,
    input  logic                  clear_all
);
    localparam int unsigned SETS = 2 ** SET_ADDR_W;

    logic [DATA_WIDTH-1:0] data_q [SETS][WORDS];
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [SETS-1:0]       valid_q;

    always_ff @(posedge clock) begin
        if (reset || clear_all) begin
            valid_q <= '0;
        end else if (install) begin
            valid_q[set_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (install) begin
            tag_q[set_idx] <= tag;
        end
        if (we) begin
            data_q[set_idx][wr_idx] <= wr_data;
        end
    end

    assign valid   = valid_q[set_idx];
    assign hit     = valid && (tag_q[set_idx] == tag);
    assign rd_word = data_q[set_idx][rd_idx];

endmodule

// File: rtl/ysyx_23060025_icache_sa.sv
// N-way set-associative instruction cache between the IFU and an AXI read port.
//   clock, reset : clock and synchronous active-high reset
//   bus          : IFU request/response, fence.i flush and AXI AR/R channels
// Hits respond two cycles after the request is sampled; misses refill the whole line
// with one INCR burst into the victim way (lowest invalid way, else per-set round-robin).
module ysyx_23060025_icache_sa
    import ysyx_23060025_icache_sa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SET_ADDR_W = 4,
    parameter int unsigned LINE_OFF_W = 4
) (
    input logic                      clock,
    input logic                      reset,
    ysyx_23060025_icache_sa_if.slave bus
);
    localparam int unsigned WORDS  = (2 ** LINE_OFF_W) / 4;
    localparam int unsigned SETS   = 2 ** SET_ADDR_W;
    localparam int unsigned TAG_W  = ADDR_WIDTH - SET_ADDR_W - LINE_OFF_W;
    localparam int unsigned WORD_W = clog2_min1(WORDS);
    localparam int unsigned WAY_W  = clog2_min1(WAYS);

    icache_state_e         state_q;
    logic                  pready_q, arvalid_q, rready_q, flush_pend_q, beat_done_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [WORD_W-1:0]     beat_cnt_q;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic [WAY_W-1:0]      rr_q [SETS];

    logic [SET_ADDR_W-1:0] set_idx;
    logic [TAG_W-1:0]      tag;
    logic [WORD_W-1:0]     word_idx;
    logic [WAYS-1:0]       way_hit, way_valid;
    logic [DATA_WIDTH-1:0] way_word [WAYS];
    logic [DATA_WIDTH-1:0] hit_word;
    logic                  fill_we, fill_last, flush_now;

    // The request address is held stable until in_pready, so it indexes the arrays directly.
    assign set_idx  = bus.in_paddr[LINE_OFF_W +: SET_ADDR_W];
    assign tag      = bus.in_paddr[ADDR_WIDTH-1 -: TAG_W];
    assign word_idx = bus.in_paddr[2 +: WORD_W];

    // Beats past the end of the line are dropped; only rlast ends the refill.
    assign fill_we   = (state_q == StRefill) && bus.out_rvalid && !beat_done_q;
    assign fill_last = (state_q == StRefill) && bus.out_rvalid && bus.out_rlast;
    assign flush_now = (state_q == StIdle) && (bus.in_flush || flush_pend_q);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        ysyx_23060025_icache_sa_way #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_W      (TAG_W),
            .SET_ADDR_W (SET_ADDR_W),
            .WORDS      (WORDS)
        ) u_way (
            .clock     (clock),
            .reset     (reset),
            .set_idx   (set_idx),
            .tag       (tag),
            .rd_idx    (word_idx),
            .hit       (way_hit[w]),
            .valid     (way_valid[w]),
            .rd_word   (way_word[w]),
            .we        (fill_we && (victim_q == WAY_W'(w))),
            .wr_idx    (beat_cnt_q),
            .wr_data   (bus.out_rdata),
            .install   (fill_last && (victim_q == WAY_W'(w))),
            .clear_all (flush_now)
        );
    end

    // At most one way hits, so OR-ing the masked words is a one-hot mux.
    always_comb begin
        hit_word = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (way_hit[i]) hit_word = hit_word | way_word[i];
        end
    end

    // Descending scan leaves the lowest-index invalid way; round-robin only if the set is full.
    always_comb begin
        victim_d = rr_q[set_idx];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) victim_d = WAY_W'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            pready_q     <= 1'b0;
            prdata_q     <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rready_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            beat_cnt_q   <= '0;
            beat_done_q  <= 1'b0;
            victim_q     <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            // A flush that arrives mid-fetch is deferred until the fetch has completed.
            if (bus.in_flush && (state_q != StIdle)) flush_pend_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_flush || flush_pend_q) begin
                        flush_pend_q <= 1'b0;
                    end else if (bus.in_psel) begin
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (|way_hit) begin
                        pready_q <= 1'b1;
                        prdata_q <= hit_word;
                        state_q  <= StResp;
                    end else begin
                        arvalid_q   <= 1'b1;
                        araddr_q    <= {bus.in_paddr[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
                        victim_q    <= victim_d;
                        beat_cnt_q  <= '0;
                        beat_done_q <= 1'b0;
                        state_q     <= StAr;
                    end
                end
                StAr: begin
                    if (bus.out_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRefill;
                    end
                end
                StRefill: begin
                    if (fill_we) begin
                        if (beat_cnt_q == word_idx) prdata_q <= bus.out_rdata;
                        if (beat_cnt_q == WORD_W'(WORDS - 1)) beat_done_q <= 1'b1;
                        else                                  beat_cnt_q  <= beat_cnt_q + 1'b1;
                    end
                    if (fill_last) begin
                        rready_q <= 1'b0;
                        pready_q <= 1'b1;
                        if (WAYS > 1) rr_q[set_idx] <= rr_q[set_idx] + 1'b1;
                        state_q  <= StResp;
                    end
                end
                StResp: begin
                    pready_q <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_pready   = pready_q;
    assign bus.in_prdata   = prdata_q;
    assign bus.out_araddr  = araddr_q;
    assign bus.out_arvalid = arvalid_q;
    assign bus.out_arlen   = arvalid_q ? 8'(WORDS - 1) : 8'd0;
    assign bus.out_arsize  = arvalid_q ? AXI_SIZE_4B : 3'b000;
    assign bus.out_arburst = arvalid_q ? AXI_BURST_INCR : 2'b00;
    assign bus.out_rready  = rready_q;

endmodule

// File: tb/tb_ysyx_23060025_icache_sa.sv
module tb_ysyx_23060025_icache_sa;
    localparam int WAYS  = 2;
    localparam int SETS  = 16;
    localparam int WORDS = 4;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ar_count = 0;
    logic [31:0] last_araddr = '0;

    // Reference model: which line tag each way of each set holds.
    logic [31:0] m_line  [SETS][WAYS];
    bit          m_valid [SETS][WAYS];
    int          m_rr    [SETS];

    ysyx_23060025_icache_sa_if ifc ();

    ysyx_23060025_icache_sa dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[15:0] ^ 16'hBEEF} ^ 32'h5A00_00A5;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) % SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s = set_of(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_line[s][w] == (a & ~32'hF)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_install(input logic [31:0] a);
        int s = set_of(a);
        int v = -1;
        for (int w = 0; w < WAYS; w++)
            if (v < 0 && !m_valid[s][w]) v = w;
        if (v < 0) v = m_rr[s];
        m_valid[s][v] = 1'b1;
        m_line[s][v]  = a & ~32'hF;
        m_rr[s]       = (m_rr[s] + 1) % WAYS;
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    endtask

    // AXI read slave: random arready delay, random gaps between beats.
    initial begin
        logic [31:0] addr;
        int dly;
        ifc.out_arready = 1'b0;
        ifc.out_rvalid  = 1'b0;
        ifc.out_rlast   = 1'b0;
        ifc.out_rdata   = '0;
        forever begin
            @(negedge clock);
            if (!reset && ifc.out_arvalid) begin
                addr = ifc.out_araddr;
                ar_count++;
                last_araddr = addr;
                check("arlen", 32'(ifc.out_arlen), 32'd3);
                check("arsize", 32'(ifc.out_arsize), 32'd2);
                check("arburst", 32'(ifc.out_arburst), 32'd1);
                dly = $urandom_range(0, 5);
                repeat (dly) begin
                    @(negedge clock);
                    check("arvalid_hold", 32'(ifc.out_arvalid), 32'd1);
                    check("araddr_hold", ifc.out_araddr, addr);
                end
                ifc.out_arready = 1'b1;
                @(negedge clock);
                ifc.out_arready = 1'b0;
                for (int b = 0; b < WORDS; b++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                    ifc.out_rvalid = 1'b1;
                    ifc.out_rdata  = mem_word(addr + 32'(4 * b));
                    ifc.out_rlast  = (b == WORDS - 1);
                    @(negedge clock);
                    ifc.out_rvalid = 1'b0;
                    ifc.out_rlast  = 1'b0;
                end
            end
        end
    end

    // Entered and left on a negedge with the cache idle.
    task automatic fetch(input logic [31:0] a, input bit flush_mid, input bit flush_start);
        int  cyc = 0;
        int  ar0;
        bit  exp_hit, flushed = 1'b0;
        if (flush_start) model_flush();
        exp_hit = model_hit(a);
        ar0 = ar_count;
        ifc.in_paddr = a;
        ifc.in_psel  = 1'b1;
        ifc.in_flush = flush_start;
        forever begin
            @(negedge clock);
            cyc++;
            ifc.in_flush = flush_mid && (cyc == 4);
            if (ifc.in_flush) flushed = 1'b1;
            if (ifc.in_pready) break;
            if (cyc > 300) begin
                check("fetch_timeout", 32'(ifc.in_pready), 32'd1);
                break;
            end
        end
        ifc.in_psel  = 1'b0;
        ifc.in_flush = 1'b0;
        check("prdata", ifc.in_prdata, mem_word(a));
        check("ar_issued", 32'(ar_count - ar0), exp_hit ? 32'd0 : 32'd1);
        if (exp_hit) check("hit_latency", 32'(cyc), 32'd2);
        else         check("araddr", last_araddr, a & ~32'hF);
        if (!exp_hit) model_install(a);
        if (flushed) model_flush();
        @(negedge clock);
        check("pready_pulse", 32'(ifc.in_pready), 32'd0);
    endtask

    task automatic flush_pulse();
        ifc.in_flush = 1'b1;
        @(negedge clock);
        ifc.in_flush = 1'b0;
        model_flush();
    endtask

    initial begin
        logic [31:0] a;
        int r;
        int guard;
        reset        = 1'b1;
        ifc.in_psel  = 1'b0;
        ifc.in_flush = 1'b0;
        ifc.in_paddr = '0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_pready", 32'(ifc.in_pready), 32'd0);
        check("rst_prdata", ifc.in_prdata, 32'd0);
        check("rst_arvalid", 32'(ifc.out_arvalid), 32'd0);
        check("rst_araddr", ifc.out_araddr, 32'd0);
        check("rst_rready", 32'(ifc.out_rready), 32'd0);

        // Cold miss, same-line hit, set conflicts with round-robin eviction.
        fetch(32'h8000_0000, 1'b0, 1'b0);
        fetch(32'h8000_0008, 1'b0, 1'b0);
        fetch(32'h8000_0100, 1'b0, 1'b0);
        fetch(32'h8000_0200, 1'b0, 1'b0);
        fetch(32'h8000_0104, 1'b0, 1'b0);
        fetch(32'h8000_0000, 1'b0, 1'b0);
        // Flush in idle, flush together with a request, flush during refill.
        flush_pulse();
        fetch(32'h8000_0000, 1'b0, 1'b0);
        fetch(32'h8000_000C, 1'b0, 1'b1);
        fetch(32'h8000_0300, 1'b1, 1'b0);
        fetch(32'h8000_0300, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            a = 32'h8000_0000 | 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 3) << 4)
                | 32'($urandom_range(0, 3) << 2);
            r = $urandom_range(0, 15);
            if (r == 0) flush_pulse();
            fetch(a, r == 1, r == 2);
        end

        // Reset in the middle of a refill: lines and round-robin state are lost.
        fetch(32'h8000_0040, 1'b0, 1'b0);
        ifc.in_paddr = 32'h8000_0050;
        ifc.in_psel  = 1'b1;
        guard = 0;
        while (!ifc.out_rready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("reach_refill", 32'(ifc.out_rready), 32'd1);
        @(negedge clock);
        reset       = 1'b1;
        ifc.in_psel = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check("midrst_rready", 32'(ifc.out_rready), 32'd0);
        check("midrst_pready", 32'(ifc.in_pready), 32'd0);
        check("midrst_arvalid", 32'(ifc.out_arvalid), 32'd0);
        fetch(32'h8000_0044, 1'b0, 1'b0);
        fetch(32'h8000_0050, 1'b0, 1'b0);
        fetch(32'h8000_0048, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
